cirno9_iob_axi_bridge: RTL and testbench

//  Downstream of cirno9_core's IOB port. Turns the core's val/rdy IOB requests into single-beat
//  AXI4 master transactions on m_axi_*, and returns read data and completion to the core.
//  Non-SRAM loads/stores reach peripherals/DRAM through this block. One outstanding request.

---
 rtl/cirno9_iob_axi_bridge_pkg.sv | 29 ++
 rtl/cirno9_iob_axi_bridge_if.sv | 70 +++++++
 rtl/cirno9_iob_axi_bridge.sv | 189 ++++++++++++++++++
 tb/tb_cirno9_iob_axi_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cirno9_iob_axi_bridge_pkg.sv
// Shared types and AXI constants for the IOB-to-AXI4 bridge.
// Imported by the interface, the bridge and its bench.
package cirno9_iob_axi_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_AW = 3'd3,
        ST_WR_B  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] AXI_LEN_1  = 8'd0;
    localparam logic [2:0] SIZE_W32   = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_NONE = 4'b0000;
    localparam logic [2:0] PROT_NONE  = 3'b000;
    localparam logic [3:0] QOS_NONE   = 4'b0000;

    function automatic logic [1:0] lsb_align(
        input logic       en,
        input logic [1:0] lsb
    );
        return en ? 2'b00 : lsb;
    endfunction

endpackage

// File: rtl/cirno9_iob_axi_bridge_if.sv
// AXI4 single-beat master bundle used by the IOB bridge.
// master drives requests, slave drives responses.
interface cirno9_iob_axi_bridge_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic [3:0]        awqos;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic [3:0]        arqos;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awlock,
        output awcache, awprot, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arlock,
        output arcache, arprot, arqos, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awlock,
        input  awcache, awprot, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arlock,
        input  arcache, arprot, arqos, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/cirno9_iob_axi_bridge.sv
// Core IOB val/rdy requests to single-beat AXI4 transactions.
// One request in flight; all AXI and IOB outputs come straight from flops.
module cirno9_iob_axi_bridge
    import cirno9_iob_axi_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int ALIGN_ADDR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hs_ls4iob_val,
    output logic              o_hs_iob4ls_rdy,
    input  logic [3:0]        i_iob_wen,
    input  logic [ADDR_W-1:0] i_adr,
    input  logic [31:0]       i_wdat,
    output logic [31:0]       o_iob_rdat,
    output logic              o_iob_err,
    cirno9_iob_axi_bridge_if.master m_axi
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdat_q, wdat_d;
    logic [3:0]        strb_q, strb_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdat_q, rdat_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;

    logic aw_hs;
    logic w_hs;
    logic unused_rlast;

    assign aw_hs = awvalid_q & m_axi.awready;
    assign w_hs  = wvalid_q & m_axi.wready;
    assign unused_rlast = m_axi.rlast;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        strb_d    = strb_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdat_d    = rdat_q;
        err_d     = 1'b0;
        rdy_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_hs_ls4iob_val) begin
                    addr_d = {i_adr[ADDR_W-1:2],
                              lsb_align(ALIGN_ADDR != 0, i_adr[1:0])};
                    wdat_d = i_wdat;
                    strb_d = i_iob_wen;
                    if (i_iob_wen == 4'b0000) begin
                        state_d   = ST_RD_A;
                        arvalid_d = 1'b1;
                    end else begin
                        state_d   = ST_WR_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end
                end
            end
            ST_RD_A: begin
                if (m_axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (m_axi.rvalid) begin
                    rready_d = 1'b0;
                    rdat_d   = m_axi.rdata;
                    err_d    = (m_axi.rresp != RESP_OKAY);
                    rdy_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_WR_AW: begin
                // AW and W complete independently, in either order
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (m_axi.bvalid) begin
                    bready_d = 1'b0;
                    err_d    = (m_axi.bresp != RESP_OKAY);
                    rdy_d    = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdat_q    <= '0;
            strb_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdat_q    <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            strb_q    <= strb_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
        end
    end

    assign o_hs_iob4ls_rdy = rdy_q;
    assign o_iob_rdat      = rdat_q;
    assign o_iob_err       = err_q;

    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = AXI_LEN_1;
    assign m_axi.awsize  = SIZE_W32;
    assign m_axi.awburst = BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = CACHE_NONE;
    assign m_axi.awprot  = PROT_NONE;
    assign m_axi.awqos   = QOS_NONE;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdat_q;
    assign m_axi.wstrb   = strb_q;
    assign m_axi.wlast   = 1'b1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = AXI_LEN_1;
    assign m_axi.arsize  = SIZE_W32;
    assign m_axi.arburst = BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = CACHE_NONE;
    assign m_axi.arprot  = PROT_NONE;
    assign m_axi.arqos   = QOS_NONE;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_cirno9_iob_axi_bridge.sv
// Bench for the IOB-to-AXI bridge: wait-state slave model,
// expected responses queued at issue and checked by a monitor.
module tb_cirno9_iob_axi_bridge;
    import cirno9_iob_axi_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        val = 1'b0;
    logic [3:0]  wen = 4'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        rdy;
    logic [31:0] rdat;
    logic        err;

    logic        val1 = 1'b0;
    logic [3:0]  wen1 = 4'b0;
    logic [31:0] adr1 = '0;
    logic [31:0] wdat1 = '0;
    logic        rdy1;
    logic [31:0] rdat1;
    logic        err1;

    cirno9_iob_axi_bridge_if #(.ADDR_W(32)) axi0 ();
    cirno9_iob_axi_bridge_if #(.ADDR_W(32)) axi1 ();

    cirno9_iob_axi_bridge #(.ADDR_W(32), .ALIGN_ADDR(1)) dut0 (
        .clk(clk), .rst(rst),
        .i_hs_ls4iob_val(val), .o_hs_iob4ls_rdy(rdy),
        .i_iob_wen(wen), .i_adr(adr), .i_wdat(wdat),
        .o_iob_rdat(rdat), .o_iob_err(err),
        .m_axi(axi0)
    );

    cirno9_iob_axi_bridge #(.ADDR_W(32), .ALIGN_ADDR(0)) dut1 (
        .clk(clk), .rst(rst),
        .i_hs_ls4iob_val(val1), .o_hs_iob4ls_rdy(rdy1),
        .i_iob_wen(wen1), .i_adr(adr1), .i_wdat(wdat1),
        .o_iob_rdat(rdat1), .o_iob_err(err1),
        .m_axi(axi1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---- slave model for dut0 with programmable wait states ----
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] rdata_cfg = '0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;

    assign axi0.arready = axi0.arvalid && (ar_cnt >= ar_wait);
    assign axi0.rvalid  = r_pend && (r_cnt >= r_wait);
    assign axi0.rdata   = rdata_cfg;
    assign axi0.rresp   = rresp_cfg;
    assign axi0.rlast   = 1'b1;
    assign axi0.awready = axi0.awvalid && (aw_cnt >= aw_wait);
    assign axi0.wready  = axi0.wvalid && (w_cnt >= w_wait);
    assign axi0.bvalid  = b_pend && (b_cnt >= b_wait);
    assign axi0.bresp   = bresp_cfg;

    wire aw_hs0 = axi0.awvalid && axi0.awready;
    wire w_hs0  = axi0.wvalid && axi0.wready;

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            ar_cnt <= (axi0.arvalid && !axi0.arready) ? ar_cnt + 1 : 0;
            aw_cnt <= (axi0.awvalid && !axi0.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (axi0.wvalid && !axi0.wready) ? w_cnt + 1 : 0;
            if (axi0.arvalid && axi0.arready) begin
                r_pend <= 1'b1; r_cnt <= 0;
            end else if (r_pend) begin
                if (axi0.rvalid && axi0.rready) r_pend <= 1'b0;
                else r_cnt <= r_cnt + 1;
            end
            if (b_pend) begin
                if (axi0.bvalid && axi0.bready) b_pend <= 1'b0;
                else b_cnt <= b_cnt + 1;
            end else if ((aw_got || aw_hs0) && (w_got || w_hs0)) begin
                b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                if (aw_hs0) aw_got <= 1'b1;
                if (w_hs0) w_got <= 1'b1;
            end
        end
    end

    // ---- always-ready slave for dut1 ----
    assign axi1.arready = 1'b1;
    assign axi1.rvalid  = axi1.rready;
    assign axi1.rdata   = 32'h5A5A_0001;
    assign axi1.rresp   = 2'b00;
    assign axi1.rlast   = 1'b1;
    assign axi1.awready = 1'b1;
    assign axi1.wready  = 1'b1;
    assign axi1.bvalid  = axi1.bready;
    assign axi1.bresp   = 2'b00;

    // ---- scoreboard ----
    typedef struct { logic [31:0] rdat; logic err; } rsp_t;
    rsp_t        sb_q[$];
    logic [31:0] addr_exp[$];
    logic [35:0] w_exp[$];
    int ar_count = 0, aw_count = 0, w_count = 0;

    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [3:0]  p_wstrb;

    always @(negedge clk) begin
        if (rst) begin
            p_arv = 1'b0; p_awv = 1'b0; p_wv = 1'b0;
        end else begin
            if (p_arv && !p_arr)
                chk("ar_stable", {axi0.arvalid, axi0.araddr}, {1'b1, p_araddr});
            if (p_arv && p_arr) chk("ar_drop", axi0.arvalid, 1'b0);
            if (p_awv && !p_awr)
                chk("aw_stable", {axi0.awvalid, axi0.awaddr}, {1'b1, p_awaddr});
            if (p_awv && p_awr) chk("aw_drop", axi0.awvalid, 1'b0);
            if (p_wv && !p_wr)
                chk("w_stable", {axi0.wvalid, axi0.wstrb, axi0.wdata},
                    {1'b1, p_wstrb, p_wdata});
            if (p_wv && p_wr) chk("w_drop", axi0.wvalid, 1'b0);
            if (axi0.arvalid && axi0.arready) begin
                ar_count++;
                if (addr_exp.size() == 0) chk("ar_unexpected", 1, 0);
                else chk("araddr", axi0.araddr, addr_exp.pop_front());
            end
            if (axi0.awvalid && axi0.awready) begin
                aw_count++;
                if (addr_exp.size() == 0) chk("aw_unexpected", 1, 0);
                else chk("awaddr", axi0.awaddr, addr_exp.pop_front());
            end
            if (axi0.wvalid && axi0.wready) begin
                w_count++;
                if (w_exp.size() == 0) chk("w_unexpected", 1, 0);
                else chk("wdata_wstrb", {axi0.wstrb, axi0.wdata}, w_exp.pop_front());
            end
            if (rdy) begin
                if (sb_q.size() == 0) chk("rdy_unexpected", 1, 0);
                else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    chk("rsp_err", err, e.err);
                    chk("rsp_rdat", rdat, e.rdat);
                end
            end
            p_arv = axi0.arvalid; p_arr = axi0.arready; p_araddr = axi0.araddr;
            p_awv = axi0.awvalid; p_awr = axi0.awready; p_awaddr = axi0.awaddr;
            p_wv = axi0.wvalid; p_wr = axi0.wready;
            p_wdata = axi0.wdata; p_wstrb = axi0.wstrb;
        end
    end

    // ---- stimulus ----
    logic [31:0] rdat_model = '0;
    int exp_ar = 0, exp_aw = 0;

    task automatic req(input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ea,
                       input logic eerr, input logic [31:0] rd,
                       input bit keep, output int lat);
        rsp_t e;
        bit got;
        addr_exp.push_back(ea);
        if (w != 4'b0000) begin
            w_exp.push_back({w, d});
            exp_aw++;
        end else begin
            exp_ar++;
            rdat_model = rd;
        end
        e.rdat = rdat_model;
        e.err  = eerr;
        sb_q.push_back(e);
        val = 1'b1; wen = w; adr = a; wdat = d;
        got = 1'b0;
        lat = -1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (rdy) begin got = 1'b1; lat = i; end
        end
        if (!got) chk("rdy_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) val = 1'b0;
    endtask

    int lat;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", {axi0.arvalid, axi0.awvalid, axi0.wvalid,
            axi0.bready, axi0.rready}, 5'b0);
        chk("rst_rdy_err", {rdy, err}, 2'b0);
        chk("rst_rdat", rdat, 32'h0);
        chk("rst_state", 32'(dut0.state_q), 32'(ST_IDLE));
        @(posedge clk); #1 rst = 1'b0;

        rdata_cfg = 32'hCAFE_F00D;
        req(4'b0000, 32'h1000_0004, 32'h0, 32'h1000_0004, 1'b0,
            32'hCAFE_F00D, 0, lat);
        chk("rd_latency", lat, 3);

        aw_wait = 2; b_wait = 1;
        req(4'b0011, 32'h3000_0008, 32'h1234_5678, 32'h3000_0008, 1'b0,
            32'h0, 0, lat);
        aw_wait = 0; b_wait = 0;

        bresp_cfg = 2'b10; w_wait = 2;
        req(4'b1111, 32'h3000_0010, 32'hA5A5_5A5A, 32'h3000_0010, 1'b1,
            32'h0, 0, lat);
        bresp_cfg = 2'b00; w_wait = 0;

        rresp_cfg = 2'b11; rdata_cfg = 32'hDEAD_BEEF;
        req(4'b0000, 32'h1000_0020, 32'h0, 32'h1000_0020, 1'b1,
            32'hDEAD_BEEF, 0, lat);
        rresp_cfg = 2'b00;

        ar_wait = 1; r_wait = 2; rdata_cfg = 32'h0BAD_F00D;
        req(4'b0000, 32'h2000_0003, 32'h0, 32'h2000_0000, 1'b0,
            32'h0BAD_F00D, 0, lat);
        chk("rd_wait_latency", lat, 6);
        ar_wait = 0; r_wait = 0;

        rdata_cfg = 32'h7777_1111;
        req(4'b1000, 32'h4000_0004, 32'h8800_0000, 32'h4000_0004, 1'b0,
            32'h0, 1, lat);
        req(4'b0000, 32'h4000_0004, 32'h0, 32'h4000_0004, 1'b0,
            32'h7777_1111, 0, lat);
        repeat (3) @(negedge clk);
        chk("b2b_ar_count", ar_count, exp_ar);
        chk("b2b_aw_count", {aw_count, w_count}, {exp_aw, exp_aw});

        // reset while RD_D waits on rvalid
        r_wait = 100;
        addr_exp.push_back(32'h5000_0000);
        exp_ar++;
        val = 1'b1; wen = 4'b0; adr = 32'h5000_0000;
        @(posedge clk); #1 val = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_state", 32'(dut0.state_q), 32'(ST_RD_D));
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        r_wait = 0;
        @(negedge clk);
        chk("mid_rst_valids", {axi0.arvalid, axi0.awvalid, axi0.wvalid,
            axi0.bready, axi0.rready, rdy}, 6'b0);
        chk("mid_rst_state", 32'(dut0.state_q), 32'(ST_IDLE));
        chk("mid_rst_rdat", rdat, 32'h0);
        @(posedge clk); #1;
        rdat_model = '0;

        rdata_cfg = 32'h1357_9BDF;
        req(4'b0000, 32'h6000_0008, 32'h0, 32'h6000_0008, 1'b0,
            32'h1357_9BDF, 0, lat);
        chk("post_rst_latency", lat, 3);

        val1 = 1'b1; wen1 = 4'b0; adr1 = 32'h2000_0003;
        begin
            bit seen_ar, seen_rdy;
            seen_ar = 1'b0; seen_rdy = 1'b0;
            for (int i = 0; i < 20 && !seen_rdy; i++) begin
                @(negedge clk);
                if (axi1.arvalid && !seen_ar) begin
                    seen_ar = 1'b1;
                    chk("noalign_araddr", axi1.araddr, 32'h2000_0003);
                end
                if (rdy1) begin
                    seen_rdy = 1'b1;
                    chk("noalign_rdat", {err1, rdat1}, {1'b0, 32'h5A5A_0001});
                end
            end
            if (!seen_ar) chk("noalign_ar_timeout", 0, 1);
            if (!seen_rdy) chk("noalign_rdy_timeout", 0, 1);
        end
        @(posedge clk); #1 val1 = 1'b0;

        repeat (4) @(negedge clk);
        chk("final_ar_count", ar_count, exp_ar);
        chk("final_sb_empty", sb_q.size() + addr_exp.size() + w_exp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
